// File: rtl/fp_addsub_unit.sv
// rtl/fp_addsub_unit.sv - multi-cycle floating-point adder/subtractor with round-to-nearest-even
// Fixed-latency FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE, four-signal handshake.
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   input_rdy,
  output logic                   input_ack,
  input  logic                   operation,
  input  logic [EXP_W+MAN_W:0]   data_a,
  input  logic [EXP_W+MAN_W:0]   data_b,
  output logic                   output_rdy,
  input  logic                   output_ack,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int LZ_W  = $clog2(EXT_W) + 1;
  localparam int EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state;
  logic [W-1:0]          r_a, r_b;
  logic                  r_sign, r_sub, r_special, r_zero;
  logic [W-1:0]          r_spec_res;
  logic [3:0]            r_spec_flags;
  logic signed [EW-1:0]  r_exp;
  logic [EXT_W-1:0]      r_big, r_small, r_norm;
  logic [EXT_W:0]        r_sum;
  logic                  r_input_ack, r_output_rdy;
  logic [W-1:0]          r_result;
  logic [3:0]            r_flags;

  logic                  w_sa, w_sb, w_za, w_zb, w_a_big;
  logic [EXP_W-1:0]      w_ea, w_eb, w_e_big, w_e_small, w_diff;
  logic [MAN_W-1:0]      w_ma, w_mb;
  logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b;
  logic [EXT_W-1:0]      w_sig_a, w_sig_b, w_small_sig, w_shr, w_small_al;
  logic                  w_lost;
  logic                  w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic                  w_special;
  logic [W-1:0]          w_spec_res;
  logic [3:0]            w_spec_flags;
  logic [EW-1:0]         w_lzc;
  logic                  w_rup, w_inex;
  logic [SIG_W:0]        w_mrnd;
  logic signed [EW-1:0]  w_exp_rnd;
  logic [MAN_W-1:0]      w_frac;

  assign w_sa = r_a[W-1];
  assign w_sb = r_b[W-1];
  assign w_ea = r_a[W-2 -: EXP_W];
  assign w_eb = r_b[W-2 -: EXP_W];
  assign w_ma = r_a[MAN_W-1:0];
  assign w_mb = r_b[MAN_W-1:0];
  assign w_za = (w_ea == '0);
  assign w_zb = (w_eb == '0);

  // Subnormals are flushed, so their fraction must not influence the magnitude compare.
  assign w_mag_a = {w_ea, w_za ? {MAN_W{1'b0}} : w_ma};
  assign w_mag_b = {w_eb, w_zb ? {MAN_W{1'b0}} : w_mb};
  assign w_a_big = (w_mag_a >= w_mag_b);
  assign w_sig_a = w_za ? {EXT_W{1'b0}} : {1'b1, w_ma, 3'b000};
  assign w_sig_b = w_zb ? {EXT_W{1'b0}} : {1'b1, w_mb, 3'b000};

  assign w_e_big     = w_a_big ? w_ea : w_eb;
  assign w_e_small   = w_a_big ? w_eb : w_ea;
  assign w_diff      = w_e_big - w_e_small;
  assign w_small_sig = w_a_big ? w_sig_b : w_sig_a;
  assign w_shr       = w_small_sig >> w_diff;
  assign w_lost      = ((w_shr << w_diff) != w_small_sig);
  assign w_small_al  = (int'(w_diff) >= EXT_W - 1) ? {{(EXT_W-1){1'b0}}, |w_small_sig}
                                                   : {w_shr[EXT_W-1:1], w_shr[0] | w_lost};

  assign w_nan_a = (w_ea == EXP_ONES) && (w_ma != '0);
  assign w_nan_b = (w_eb == EXP_ONES) && (w_mb != '0);
  assign w_inf_a = (w_ea == EXP_ONES) && (w_ma == '0);
  assign w_inf_b = (w_eb == EXP_ONES) && (w_mb == '0);

  always_comb begin
    w_special    = 1'b0;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) begin
      w_special    = 1'b1;
      w_spec_res   = QNAN;
      w_spec_flags = 4'b1000;
    end else if (w_inf_a) begin
      w_special  = 1'b1;
      w_spec_res = r_a;
    end else if (w_inf_b) begin
      w_special  = 1'b1;
      w_spec_res = r_b;
    end
  end

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (r_sum[i]) w_lzc = EW'(EXT_W - 1 - i);
    end
  end

  assign w_rup     = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
  assign w_inex    = |r_norm[2:0];
  assign w_mrnd    = {1'b0, r_norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, w_rup};
  assign w_exp_rnd = r_exp + {{(EW-1){1'b0}}, w_mrnd[SIG_W]};
  assign w_frac    = w_mrnd[SIG_W] ? w_mrnd[SIG_W-1:1] : w_mrnd[MAN_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sign       <= 1'b0;
      r_sub        <= 1'b0;
      r_special    <= 1'b0;
      r_zero       <= 1'b0;
      r_spec_res   <= '0;
      r_spec_flags <= '0;
      r_exp        <= '0;
      r_big        <= '0;
      r_small      <= '0;
      r_norm       <= '0;
      r_sum        <= '0;
      r_input_ack  <= 1'b0;
      r_output_rdy <= 1'b0;
      r_result     <= '0;
      r_flags      <= '0;
    end else begin
      r_input_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (input_rdy) begin
            r_a         <= data_a;
            r_b         <= {data_b[W-1] ^ operation, data_b[W-2:0]};
            r_input_ack <= 1'b1;
            r_state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign       <= w_a_big ? w_sa : w_sb;
          r_sub        <= w_sa ^ w_sb;
          r_exp        <= {{(EW-EXP_W){1'b0}}, w_e_big};
          r_big        <= w_a_big ? w_sig_a : w_sig_b;
          r_small      <= w_small_al;
          r_special    <= w_special;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
          r_state      <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small}) : ({1'b0, r_big} + {1'b0, r_small});
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_zero <= 1'b0;
          if (r_sum[EXT_W]) begin
            r_norm <= {r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + EXP_ONE;
          end else if (r_sum == '0) begin
            r_norm <= '0;
            r_zero <= 1'b1;
          end else begin
            r_norm <= r_sum[EXT_W-1:0] << w_lzc;
            r_exp  <= r_exp - w_lzc;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (r_special) begin
            r_result <= r_spec_res;
            r_flags  <= r_spec_flags;
          end else if (r_zero) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
          end else if (r_exp <= EXP_ZERO) begin
            r_result <= {r_sign, {(W-1){1'b0}}};
            r_flags  <= 4'b0011;
          end else if (w_exp_rnd >= EXP_MAX) begin
            r_result <= {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            r_flags  <= 4'b0101;
          end else begin
            r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac};
            r_flags  <= {3'b000, w_inex};
          end
          r_output_rdy <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (output_ack) begin
            r_output_rdy <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign input_ack  = r_input_ack;
  assign output_rdy = r_output_rdy;
  assign result     = r_result;
  assign flags      = r_flags;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// tb/tb_fp_addsub_unit.sv - self-checking bench for fp_addsub_unit (single precision)
// Vector table plus hand-written handshake and reset sequences, scoreboard-compared.
module tb_fp_addsub_unit;

  logic        clock;
  logic        reset;
  logic        input_rdy;
  logic        input_ack;
  logic        operation;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        output_rdy;
  logic        output_ack;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb_q[$];

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs [16];

  fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .reset(reset), .input_rdy(input_rdy), .input_ack(input_ack),
    .operation(operation), .data_a(data_a), .data_b(data_b), .output_rdy(output_rdy),
    .output_ack(output_ack), .result(result), .flags(flags)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic pop_compare(input string nm);
    logic [35:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", nm);
    end else begin
      e = sb_q.pop_front();
      check({nm, "_result"}, 64'(result), 64'(e[35:4]));
      check({nm, "_flags"}, 64'(flags), 64'(e[3:0]));
    end
  endtask

  // Called at the negedge right after the capture edge.
  task automatic wait_out(input string nm);
    int cnt;
    cnt = 0;
    while (!output_rdy && cnt < 12) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) check({nm, "_input_ack_drop"}, 64'(input_ack), 64'd0);
    end
    check({nm, "_latency"}, 64'(cnt), 64'd4);
  endtask

  task automatic release_out(input string nm);
    output_ack = 1'b1;
    @(negedge clock);
    output_ack = 1'b0;
    check({nm, "_output_rdy_clear"}, 64'(output_rdy), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef);
    @(negedge clock);
    input_rdy = 1'b1;
    operation = op;
    data_a    = a;
    data_b    = b;
    sb_q.push_back({er, ef});
    @(negedge clock);
    input_rdy = 1'b0;
    check({nm, "_input_ack_pulse"}, 64'(input_ack), 64'd1);
    wait_out(nm);
    pop_compare(nm);
    release_out(nm);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{1'b1, 32'h3F800000, 32'h41433333, 32'hC1333333, 4'b0000};
    vecs[2]  = '{1'b0, 32'hC1333333, 32'h41333333, 32'h00000000, 4'b0000};
    vecs[3]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[4]  = '{1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{1'b0, 32'h7F800000, 32'hBF800000, 32'h7F800000, 4'b0000};
    vecs[6]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
    vecs[7]  = '{1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 4'b0011};
    vecs[8]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
    vecs[9]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
    vecs[10] = '{1'b1, 32'h40000000, 32'h40000000, 32'h00000000, 4'b0000};
    vecs[11] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vecs[12] = '{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000};
    vecs[13] = '{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[14] = '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001};
    vecs[15] = '{1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 4'b0001};

    reset = 1'b0; input_rdy = 1'b0; operation = 1'b0;
    data_a = '0; data_b = '0; output_ack = 1'b0;
    #1;
    check("reset_input_ack", 64'(input_ack), 64'd0);
    check("reset_output_rdy", 64'(output_rdy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);
    end

    // Consumer stalls with a producer waiting; result must stay put and nothing is captured.
    @(negedge clock);
    input_rdy = 1'b1; operation = 1'b0;
    data_a = 32'h3F800000; data_b = 32'h40000000;
    sb_q.push_back({32'h40400000, 4'b0000});
    @(negedge clock);
    data_a = 32'h40000000; data_b = 32'h40000000;
    check("hold_input_ack_pulse", 64'(input_ack), 64'd1);
    wait_out("hold");
    pop_compare("hold");
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("hold%0d_result", k), 64'(result), 64'h40400000);
      check($sformatf("hold%0d_output_rdy", k), 64'(output_rdy), 64'd1);
      check($sformatf("hold%0d_input_ack", k), 64'(input_ack), 64'd0);
    end
    output_ack = 1'b1;
    sb_q.push_back({32'h40800000, 4'b0000});
    @(negedge clock);
    output_ack = 1'b0;
    check("bubble_output_rdy", 64'(output_rdy), 64'd0);
    check("bubble_input_ack", 64'(input_ack), 64'd0);
    @(negedge clock);
    input_rdy = 1'b0;
    check("after_bubble_input_ack", 64'(input_ack), 64'd1);
    wait_out("after_bubble");
    pop_compare("after_bubble");
    release_out("after_bubble");

    // Reset arrives while the operation sits in ALIGN; it is discarded.
    @(negedge clock);
    input_rdy = 1'b1; operation = 1'b0;
    data_a = 32'h3F800000; data_b = 32'h3F800000;
    @(posedge clock);
    #2;
    reset = 1'b0;
    input_rdy = 1'b0;
    #1;
    check("midreset_input_ack", 64'(input_ack), 64'd0);
    check("midreset_output_rdy", 64'(output_rdy), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_flags", 64'(flags), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("midreset_discarded", 64'(output_rdy), 64'd0);
    run_op("post_reset", 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000);

    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
